// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if
//   Bundles the command handshake and the open-drain pad signals of the
//   PS/2 host transmitter.
//   master : command source plus the pad environment (drives tx_data,
//            tx_start and the pad input values; observes status and output
//            enables).
//   slave  : the transmitter itself.
//   Signals:
//     tx_data[7:0]  byte to send, sampled on an accepted tx_start
//     tx_start      send request, accepted only while idle
//     busy          transfer in progress
//     tx_done       1-cycle pulse, frame sent and acknowledged
//     tx_error      1-cycle pulse, no acknowledge or timeout
//     ps2_clk_in    pad value of the PS/2 clock line (asynchronous)
//     ps2_data_in   pad value of the PS/2 data line (asynchronous)
//     ps2_clk_oe    1 = pull the PS/2 clock line low
//     ps2_data_oe   1 = pull the PS/2 data line low
`timescale 1ns/1ps
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       tx_done;
  logic       tx_error;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_data, tx_start, ps2_clk_in, ps2_data_in,
    input  busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_data, tx_start, ps2_clk_in, ps2_data_in,
    output busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte to the device:
//   inhibits the bus, issues a request-to-send, shifts start/data/parity/stop
//   out on device-generated clocks and checks the device acknowledge.
//   Pads are open-drain and controlled through output enables; busy lets the
//   receive path ignore bus activity caused by this transfer.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    ps2_host_tx_if.slave (handshake, status, pad values/enables)
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 1600,
  parameter int REQ_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 320000,
  parameter int CNT_W          = 19
) (
  input logic          clk,
  input logic          rst_n,
  ps2_host_tx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       bit_cnt_reg;
  logic [9:0]       frame_reg;
  logic             ack_ok_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             error_reg;
  logic             clk_oe_reg;
  logic             data_oe_reg;

  logic             clk_meta_reg;
  logic             clk_sync_reg;
  logic             clk_prev_reg;
  logic             data_meta_reg;
  logic             data_sync_reg;

  logic             clk_fall;
  logic             timeout_hit;

  // Pad synchronizers. Idle lines are pulled high, so reset to 1 to avoid
  // a phantom falling edge right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_reg  <= 1'b1;
      clk_sync_reg  <= 1'b1;
      clk_prev_reg  <= 1'b1;
      data_meta_reg <= 1'b1;
      data_sync_reg <= 1'b1;
    end else begin
      clk_meta_reg  <= bus.ps2_clk_in;
      clk_sync_reg  <= clk_meta_reg;
      clk_prev_reg  <= clk_sync_reg;
      data_meta_reg <= bus.ps2_data_in;
      data_sync_reg <= data_meta_reg;
    end
  end

  assign clk_fall = clk_prev_reg & ~clk_sync_reg;

  // The shared counter restarts at 0 when SHIFT is entered, so from there on
  // it measures the whole device-clocked part of the transfer.
  assign timeout_hit = ((state_reg == SHIFT) || (state_reg == ACK) ||
                        (state_reg == WAIT_IDLE)) && (cnt_reg == TO_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      frame_reg   <= '0;
      ack_ok_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
    end else begin
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      if (timeout_hit) begin
        state_reg   <= IDLE;
        clk_oe_reg  <= 1'b0;
        data_oe_reg <= 1'b0;
        busy_reg    <= 1'b0;
        error_reg   <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            clk_oe_reg  <= 1'b0;
            data_oe_reg <= 1'b0;
            if (bus.tx_start) begin
              // {stop, odd parity, data}; shifted out LSB first
              frame_reg   <= {1'b1, ~^bus.tx_data, bus.tx_data};
              busy_reg    <= 1'b1;
              cnt_reg     <= '0;
              bit_cnt_reg <= '0;
              clk_oe_reg  <= 1'b1;
              state_reg   <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (cnt_reg == INH_LAST) begin
              cnt_reg     <= '0;
              data_oe_reg <= 1'b1;  // start bit
              state_reg   <= REQ;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
          REQ: begin
            if (cnt_reg == REQ_LAST) begin
              cnt_reg    <= '0;
              clk_oe_reg <= 1'b0;   // hand the clock to the device
              state_reg  <= SHIFT;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
          SHIFT: begin
            cnt_reg <= cnt_reg + CNT_ONE;
            if (clk_fall) begin
              // Edges 1..9 put D0..D7 and parity on the wire; edge 10 puts
              // the stop bit (1), which releases the data line.
              data_oe_reg <= ~frame_reg[0];
              frame_reg   <= {1'b0, frame_reg[9:1]};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == 4'd9) begin
                state_reg <= ACK;
              end
            end
          end
          ACK: begin
            cnt_reg <= cnt_reg + CNT_ONE;
            if (clk_fall) begin
              ack_ok_reg <= ~data_sync_reg;
              state_reg  <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            cnt_reg <= cnt_reg + CNT_ONE;
            if (clk_sync_reg && data_sync_reg) begin
              busy_reg  <= 1'b0;
              done_reg  <= ack_ok_reg;
              error_reg <= ~ack_ok_reg;
              state_reg <= IDLE;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.tx_done     = done_reg;
  assign bus.tx_error    = error_reg;
  assign bus.ps2_clk_oe  = clk_oe_reg;
  assign bus.ps2_data_oe = data_oe_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
//   Bench for ps2_host_tx. A PS/2 device model clocks frames out of the
//   transmitter over wired-AND pads; expected frames and outcomes are queued
//   when a command is issued and compared when the wire/status produce them.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 1600;
  localparam int REQ  = 16;
  localparam int TO   = 3000;
  localparam int CW   = 12;
  localparam int HALF = 40;

  localparam int M_ACK    = 0;
  localparam int M_NACK   = 1;
  localparam int M_SILENT = 2;
  localparam int M_RESET  = 3;

  typedef struct {
    logic [7:0] data;
    int         mode;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  exp_t sb[$];

  always #5 clk = ~clk;

  ps2_host_tx_if bus();

  // Open-drain wired-AND of host and device drivers
  assign bus.ps2_clk_in  = dev_clk & ~bus.ps2_clk_oe;
  assign bus.ps2_data_in = dev_data & ~bus.ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (REQ),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2) == 0;
  endfunction

  always @(negedge clk) begin
    if (bus.tx_done) done_cnt++;
    if (bus.tx_error) err_cnt++;
    if (bus.tx_done && bus.tx_error) both_cnt++;
  end

  // Device side: sample start bit, then 10 clocks (data, parity, stop) with
  // sampling on rising edges, then the ACK clock.
  task automatic dev_frame(input int mode, input bit inject,
                           output logic [10:0] bits, output bit aborted);
    aborted = 1'b0;
    bits = '0;
    repeat (HALF) @(negedge clk);
    bits[0] = bus.ps2_data_in;
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      if (mode == M_RESET && i == 5) begin
        repeat (6) @(negedge clk);
        check("pre_rst_data_oe", 32'(bus.ps2_data_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_clk_oe", 32'(bus.ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(bus.ps2_data_oe), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dev_clk = 1'b1;
        aborted = 1'b1;
        return;
      end
      if (inject && i == 5) begin
        @(negedge clk);
        bus.tx_data = 8'h55;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        repeat (HALF - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_clk = 1'b1;
      bits[i] = bus.ps2_data_in;
      repeat (HALF) @(negedge clk);
    end
    if (mode == M_ACK) dev_data = 1'b0;
    repeat (4) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    dev_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] data, input int mode, input bit inject);
    exp_t        e;
    logic [10:0] bits;
    logic [10:0] exp_bits;
    bit          aborted;
    logic        pb;
    int          n;
    int          d0;
    int          e0;
    d0 = done_cnt;
    e0 = err_cnt;
    aborted = 1'b0;
    bits = '0;
    @(negedge clk);
    bus.tx_data = data;
    bus.tx_start = 1'b1;
    e.data = data;
    e.mode = mode;
    sb.push_back(e);
    @(negedge clk);
    bus.tx_start = 1'b0;
    check("busy_accept", 32'(bus.busy), 32'd1);
    n = 0;
    while (bus.ps2_clk_oe && !bus.ps2_data_oe && n < INH + 50) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", 32'(n), 32'(INH));
    n = 0;
    while (bus.ps2_clk_oe && bus.ps2_data_oe && n < REQ + 50) begin
      n++;
      @(negedge clk);
    end
    check("req_len", 32'(n), 32'(REQ));
    if (mode == M_SILENT) begin
      n = 0;
      while (!bus.tx_error && n < TO + 100) begin
        n++;
        @(negedge clk);
      end
      e = sb.pop_front();
      check("timeout_in_window", 32'(n >= TO && n <= TO + 4), 32'd1);
      check("timeout_busy", 32'(bus.busy), 32'd0);
    end else begin
      dev_frame(mode, inject, bits, aborted);
      e = sb.pop_front();
      if (!aborted) begin
        exp_bits = {1'b1, odd_par(e.data), e.data, 1'b0};
        check("wire_bits", 32'(bits), 32'(exp_bits));
        n = 0;
        pb = bus.busy;
        while (!(bus.tx_done || bus.tx_error) && n < 200) begin
          pb = bus.busy;
          n++;
          @(negedge clk);
        end
        check("done_pulse", 32'(bus.tx_done), 32'(e.mode == M_ACK));
        check("error_pulse", 32'(bus.tx_error), 32'(e.mode != M_ACK));
        check("busy_before_pulse", 32'(pb), 32'd1);
        check("busy_at_pulse", 32'(bus.busy), 32'd0);
      end
    end
    repeat (20) @(negedge clk);
    check("oe_after", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
    check("pulse_count", 32'((done_cnt - d0) + (err_cnt - e0)), aborted ? 32'd0 : 32'd1);
    check("done_error_exclusive", 32'(both_cnt), 32'd0);
    $display("txn data=%02h mode=%0d inject=%0d wire=%03h done=%0d err=%0d",
             data, mode, inject, bits, done_cnt - d0, err_cnt - e0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tx_data = 8'h00;
    bus.tx_start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy0", 32'(bus.busy), 32'd0);
    check("rst_done0", 32'(bus.tx_done), 32'd0);
    check("rst_error0", 32'(bus.tx_error), 32'd0);
    check("rst_clk_oe0", 32'(bus.ps2_clk_oe), 32'd0);
    check("rst_data_oe0", 32'(bus.ps2_data_oe), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send(8'hED, M_ACK, 1'b0);
    send(8'h00, M_ACK, 1'b0);
    send(8'hF4, M_ACK, 1'b0);
    send(8'hA5, M_NACK, 1'b0);
    send(8'h3C, M_SILENT, 1'b0);
    send(8'hED, M_ACK, 1'b1);
    send(8'hED, M_RESET, 1'b0);
    send(8'hFF, M_ACK, 1'b0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
